swivm_uart_tx: RTL and testbench

Serial transmit end of the SwiVM character-output interface. Accepts the CPU's outbyte/outbyte_valid single-cycle pulses, buffers them in a small FIFO, and serialises each byte as an 8N1 UART frame on txd. The CPU side has no backpressure, so the FIFO absorbs bursts. Overflow is flagged, never stalled.

---
 rtl/swivm_uart_tx.sv | 149 ++++++++++++++
 tb/tb_swivm_uart_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/swivm_uart_tx.sv
// SwiVM character-output UART transmitter: CPU byte pulses are queued in a
// small FIFO and serialised as 8N1 frames on txd, with no backpressure to the CPU.
module swivm_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       outbyte,
  input  logic             outbyte_valid,
  output logic             txd,
  output logic             busy,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int          DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [DEPTH];

  logic       full, nonempty, pop, wr_en, bit_end;
  logic [7:0] head;

  // Count can reach exactly DEPTH, which is the only value with the MSB set.
  assign full     = cnt_q[FIFO_AW];
  assign nonempty = |cnt_q;
  assign head     = mem_q[rd_ptr_q];
  assign bit_end  = (baud_q == BAUD_MAX);

  // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
  assign wr_en = outbyte_valid & (~full | pop);

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? 16'd0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        txd_d  = 1'b1;
        if (nonempty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so queued frames are gapless.
          if (nonempty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q | (outbyte_valid & full & ~pop);
    cnt_d      = cnt_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= outbyte;
  end

  assign txd        = txd_q;
  assign busy       = (state_q != IDLE) | nonempty;
  assign overflow   = overflow_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_swivm_uart_tx.sv
// Directed bench for swivm_uart_tx at CLKS_PER_BIT=4, depth 16: exact txd
// timing, gapless chaining, overflow, pointer wrap, async reset, full write+pop.
module tb_swivm_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] outbyte;
  logic       outbyte_valid;
  logic       txd;
  logic       busy;
  logic       overflow;
  logic [4:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  swivm_uart_tx #(.CLKS_PER_BIT(4), .FIFO_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .outbyte(outbyte), .outbyte_valid(outbyte_valid),
    .txd(txd), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line receiver: negedge index 0 is the first low sample of a start bit,
  // data bit i is sampled at 4*(i+1)+2, stop bit at 38.
  logic [7:0] rx_q[$];
  int         dc_idx = 0;
  logic       dc_act = 1'b0;
  logic [7:0] dc_sh  = 8'h00;
  int         frame_err = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dc_act = 1'b0;
      dc_idx = 0;
    end else if (!dc_act) begin
      if (txd === 1'b0) begin
        dc_act = 1'b1;
        dc_idx = 1;
      end
    end else begin
      if (dc_idx >= 6 && dc_idx <= 34 && (dc_idx % 4) == 2) dc_sh[(dc_idx - 6) / 4] = txd;
      if (dc_idx == 38) begin
        if (txd !== 1'b1) frame_err++;
        rx_q.push_back(dc_sh);
      end
      if (dc_idx == 39) dc_act = 1'b0;
      else dc_idx++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    logic [7:0] d1;
    logic       exp_txd;
    int         idx;
    logic       saw_low;

    rst_n         = 1'b0;
    outbyte       = 8'h00;
    outbyte_valid = 1'b0;
    repeat (3) tick();
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: single 0x41 frame, cycle-exact waveform
    d1 = 8'h41;
    rx_q.delete();
    outbyte = d1; outbyte_valid = 1'b1;
    tick();
    outbyte_valid = 1'b0;
    chk("t1_cnt_after_wr", 32'(fifo_count), 32'd1);
    chk("t1_busy_rise", 32'(busy), 32'd1);
    chk("t1_txd_idle", 32'(txd), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      idx = (k - 1) / 4;
      if (idx == 0)      exp_txd = 1'b0;
      else if (idx == 9) exp_txd = 1'b1;
      else               exp_txd = d1[idx - 1];
      chk("t1_txd_wave", 32'(txd), 32'(exp_txd));
      if (k == 1)  chk("t1_cnt_after_pop", 32'(fifo_count), 32'd0);
      if (k == 40) chk("t1_busy_last_stop", 32'(busy), 32'd1);
    end
    tick();
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_txd_end", 32'(txd), 32'd1);
    chk("t1_ovf", 32'(overflow), 32'd0);
    repeat (2) tick();
    chk("t1_rx_len", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) chk("t1_rx_byte", 32'(rx_q[0]), 32'h41);

    // 2: back-to-back 0x55, 0xAA with no gap
    rx_q.delete();
    outbyte = 8'h55; outbyte_valid = 1'b1;
    tick();
    outbyte = 8'hAA;
    tick();
    outbyte_valid = 1'b0;
    chk("t2_cnt_wr_pop", 32'(fifo_count), 32'd1);
    chk("t2_txd_start1", 32'(txd), 32'd0);
    repeat (39) tick();
    chk("t2_txd_stop1", 32'(txd), 32'd1);
    tick();
    chk("t2_txd_start2", 32'(txd), 32'd0);
    chk("t2_cnt_pop2", 32'(fifo_count), 32'd0);
    repeat (39) tick();
    chk("t2_txd_stop2", 32'(txd), 32'd1);
    chk("t2_busy_e80", 32'(busy), 32'd1);
    tick();
    chk("t2_busy_e81", 32'(busy), 32'd0);
    repeat (2) tick();
    chk("t2_rx_len", rx_q.size(), 32'd2);
    if (rx_q.size() == 2) begin
      chk("t2_rx0", 32'(rx_q[0]), 32'h55);
      chk("t2_rx1", 32'(rx_q[1]), 32'hAA);
    end

    // 3: overflow with 18 consecutive writes
    rx_q.delete();
    outbyte_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      outbyte = 8'(i);
      tick();
      if (i == 0)  chk("t3_cnt_e0", 32'(fifo_count), 32'd1);
      if (i == 1)  chk("t3_cnt_e1", 32'(fifo_count), 32'd1);
      if (i == 16) chk("t3_cnt_peak", 32'(fifo_count), 32'd16);
      if (i == 16) chk("t3_ovf_before", 32'(overflow), 32'd0);
    end
    outbyte_valid = 1'b0;
    chk("t3_cnt_drop", 32'(fifo_count), 32'd16);
    chk("t3_ovf_set", 32'(overflow), 32'd1);
    wait_idle(900);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    chk("t3_rx_len", rx_q.size(), 32'd17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) chk("t3_rx_byte", 32'(rx_q[i]), 32'(i));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);

    // 4: pointer wrap over three drained bursts of 12
    rx_q.delete();
    for (int b = 0; b < 3; b++) begin
      outbyte_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
        outbyte = 8'(b * 12 + i + 8'h40);
        tick();
      end
      outbyte_valid = 1'b0;
      chk("t4_cnt_burst", 32'(fifo_count), 32'd11);
      wait_idle(700);
    end
    chk("t4_rx_len", rx_q.size(), 32'd36);
    for (int i = 0; i < 36 && i < rx_q.size(); i++) chk("t4_rx_byte", 32'(rx_q[i]), 32'(i + 8'h40));
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_cnt", 32'(fifo_count), 32'd0);

    // 5: async reset in data bit 3 of 0xF0 with two bytes queued
    rx_q.delete();
    outbyte_valid = 1'b1;
    outbyte = 8'hF0; tick();
    outbyte = 8'h01; tick();
    outbyte = 8'h02; tick();
    outbyte_valid = 1'b0;
    repeat (16) tick();
    chk("t5_txd_bit3", 32'(txd), 32'd0);
    chk("t5_cnt_queued", 32'(fifo_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_txd", 32'(txd), 32'd1);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_cnt", 32'(fifo_count), 32'd0);
    #2;
    rst_n = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
    end
    chk("t5_quiet_after", 32'(saw_low), 32'd0);
    chk("t5_rx_len", rx_q.size(), 32'd0);

    // 6: write lands on STOP->START pop edge while full
    rx_q.delete();
    outbyte_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      outbyte = 8'(8'h20 + i);
      tick();
    end
    outbyte_valid = 1'b0;
    chk("t6_cnt_full", 32'(fifo_count), 32'd16);
    repeat (24) tick();
    chk("t6_cnt_e40", 32'(fifo_count), 32'd16);
    chk("t6_txd_stop", 32'(txd), 32'd1);
    outbyte = 8'h31; outbyte_valid = 1'b1;
    tick();
    outbyte_valid = 1'b0;
    chk("t6_cnt_wr_pop", 32'(fifo_count), 32'd16);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_txd_start", 32'(txd), 32'd0);
    wait_idle(900);
    chk("t6_rx_len", rx_q.size(), 32'd18);
    for (int i = 0; i < 18 && i < rx_q.size(); i++) chk("t6_rx_byte", 32'(rx_q[i]), 32'(8'h20 + i));
    chk("t6_ovf_end", 32'(overflow), 32'd0);
    chk("frame_stop_errors", 32'(frame_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
